// File: rtl/player_input_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module : player_input_capture_pkg
// Desc   : Shared constants for the player input capture front end
// Rev    : 1.0 - initial release
// ============================================================================
package player_input_capture_pkg;

  localparam int INPUT_DEPTH_DEFAULT     = 5;
  localparam int BTN_LEFT                = 0;
  localparam int BTN_RIGHT               = 1;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int CNT_WIDTH_DEFAULT       = 16;

endpackage : player_input_capture_pkg
`default_nettype wire

// File: rtl/player_input_capture_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module : player_input_capture_button_debouncer
// Desc   : Single-bit two-flop synchroniser plus hold-time debouncer
// Rev    : 1.0 - initial release
// ============================================================================
module player_input_capture_button_debouncer
  import player_input_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT,
  parameter bit RELEASED_LEVEL  = 1'b1
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable
);

  localparam logic [CNT_WIDTH-1:0] c_last = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_stable;
  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any cycle agreeing with the stable level restarts the hold count.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_stable <= RELEASED_LEVEL;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;

endmodule : player_input_capture_button_debouncer
`default_nettype wire

// File: rtl/player_input_capture.sv
`default_nettype none
// ============================================================================
// Module : player_input_capture
// Desc   : Debounced, SOCD-resolved per-frame button capture for two players
// Rev    : 1.0 - initial release
// ============================================================================
module player_input_capture
  import player_input_capture_pkg::*;
#(
  parameter int INPUT_DEPTH       = INPUT_DEPTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH         = CNT_WIDTH_DEFAULT,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   frame_clk,
  input  logic [INPUT_DEPTH-1:0] raw_p1,
  input  logic [INPUT_DEPTH-1:0] raw_p2,
  input  logic                   win_reset,
  input  logic                   done_gen,
  output logic [INPUT_DEPTH-1:0] p1_inputs,
  output logic [INPUT_DEPTH-1:0] p2_inputs,
  output logic [INPUT_DEPTH-1:0] p1_pressed,
  output logic [INPUT_DEPTH-1:0] p2_pressed,
  output logic                   frame_strobe,
  output logic                   frame_overrun
);

  localparam logic [INPUT_DEPTH-1:0] c_polarity = {INPUT_DEPTH{BUTTON_ACTIVE_LOW}};

  logic [2*INPUT_DEPTH-1:0] w_raw_all;
  logic [2*INPUT_DEPTH-1:0] w_stable_all;
  logic [INPUT_DEPTH-1:0]   w_level_p1;
  logic [INPUT_DEPTH-1:0]   w_level_p2;
  logic                     w_frame_edge;

  logic r_frame_sync1;
  logic r_frame_sync2;
  logic r_frame_sync3;
  logic r_win_sync1;
  logic r_win_sync2;

  logic [INPUT_DEPTH-1:0] r_prev_p1;
  logic [INPUT_DEPTH-1:0] r_prev_p2;
  logic [INPUT_DEPTH-1:0] r_inputs_p1;
  logic [INPUT_DEPTH-1:0] r_inputs_p2;
  logic [INPUT_DEPTH-1:0] r_pressed_p1;
  logic [INPUT_DEPTH-1:0] r_pressed_p2;
  logic                   r_strobe;
  logic                   r_overrun;

  assign w_raw_all = {raw_p2, raw_p1};

  // Low half of the debouncer bank is player 1, high half player 2.
  for (genvar gi = 0; gi < 2 * INPUT_DEPTH; gi++) begin : g_btn
    player_input_capture_button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH),
      .RELEASED_LEVEL  (BUTTON_ACTIVE_LOW)
    ) u_debouncer (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .i_raw    (w_raw_all[gi]),
      .o_stable (w_stable_all[gi])
    );
  end

  // Opposing directions held together cancel out to neutral.
  always_comb begin
    w_level_p1 = w_stable_all[INPUT_DEPTH-1:0] ^ c_polarity;
    w_level_p2 = w_stable_all[2*INPUT_DEPTH-1:INPUT_DEPTH] ^ c_polarity;
    if (w_level_p1[BTN_LEFT] && w_level_p1[BTN_RIGHT]) begin
      w_level_p1[BTN_LEFT]  = 1'b0;
      w_level_p1[BTN_RIGHT] = 1'b0;
    end
    if (w_level_p2[BTN_LEFT] && w_level_p2[BTN_RIGHT]) begin
      w_level_p2[BTN_LEFT]  = 1'b0;
      w_level_p2[BTN_RIGHT] = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_frame_sync1 <= 1'b0;
      r_frame_sync2 <= 1'b0;
      r_frame_sync3 <= 1'b0;
      r_win_sync1   <= 1'b1;
      r_win_sync2   <= 1'b1;
    end else begin
      r_frame_sync1 <= frame_clk;
      r_frame_sync2 <= r_frame_sync1;
      r_frame_sync3 <= r_frame_sync2;
      r_win_sync1   <= win_reset;
      r_win_sync2   <= r_win_sync1;
    end
  end

  assign w_frame_edge = r_frame_sync2 & ~r_frame_sync3;

  // prev tracks through lockout so a held button is not reported as new on release.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_prev_p1    <= '0;
      r_prev_p2    <= '0;
      r_inputs_p1  <= '0;
      r_inputs_p2  <= '0;
      r_pressed_p1 <= '0;
      r_pressed_p2 <= '0;
      r_strobe     <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_strobe <= w_frame_edge;
      if (w_frame_edge && !done_gen) begin
        r_overrun <= 1'b1;
      end
      if (w_frame_edge) begin
        r_prev_p1 <= w_level_p1;
        r_prev_p2 <= w_level_p2;
        if (r_win_sync2) begin
          r_inputs_p1  <= w_level_p1;
          r_inputs_p2  <= w_level_p2;
          r_pressed_p1 <= w_level_p1 & ~r_prev_p1;
          r_pressed_p2 <= w_level_p2 & ~r_prev_p2;
        end else begin
          r_inputs_p1  <= '0;
          r_inputs_p2  <= '0;
          r_pressed_p1 <= '0;
          r_pressed_p2 <= '0;
        end
      end
    end
  end

  assign p1_inputs     = r_inputs_p1;
  assign p2_inputs     = r_inputs_p2;
  assign p1_pressed    = r_pressed_p1;
  assign p2_pressed    = r_pressed_p2;
  assign frame_strobe  = r_strobe;
  assign frame_overrun = r_overrun;

endmodule : player_input_capture
`default_nettype wire

// File: tb/tb_player_input_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_player_input_capture
// Desc   : Directed and randomized bench for player_input_capture
// Rev    : 1.0 - initial release
// ============================================================================
module tb_player_input_capture;

  localparam int N = 5;
  localparam int D = 4;

  logic         sys_clk   = 1'b0;
  logic         rst       = 1'b0;
  logic         frame_clk = 1'b0;
  logic         win_reset = 1'b1;
  logic         done_gen  = 1'b1;
  logic [N-1:0] raw_p1    = '1;
  logic [N-1:0] raw_p2    = '1;
  logic [N-1:0] p1_inputs, p2_inputs, p1_pressed, p2_pressed;
  logic         frame_strobe, frame_overrun;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  player_input_capture #(
    .INPUT_DEPTH       (N),
    .DEBOUNCE_CYCLES   (D),
    .CNT_WIDTH         (4),
    .BUTTON_ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .frame_clk     (frame_clk),
    .raw_p1        (raw_p1),
    .raw_p2        (raw_p2),
    .win_reset     (win_reset),
    .done_gen      (done_gen),
    .p1_inputs     (p1_inputs),
    .p2_inputs     (p2_inputs),
    .p1_pressed    (p1_pressed),
    .p2_pressed    (p2_pressed),
    .frame_strobe  (frame_strobe),
    .frame_overrun (frame_overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: input history snapshots, a sliding debounce window and
  // per-frame latch rules.
  typedef struct packed {
    logic [2*N-1:0] raw;
    logic           frm;
    logic           win;
  } snap_t;

  snap_t          hist[$];
  logic [2*N-1:0] win_q[$];
  logic [2*N-1:0] m_stable;
  logic [N-1:0]   m_prev1, m_prev2, m_in1, m_in2, m_pr1, m_pr2;
  logic           m_strobe, m_over;

  function automatic logic [N-1:0] level_of(input logic [N-1:0] st);
    logic [N-1:0] v;
    v = ~st;
    if (v[0] && v[1]) v[1:0] = 2'b00;
    return v;
  endfunction

  task automatic model_reset();
    snap_t rs;
    rs.raw = '0;
    rs.frm = 1'b0;
    rs.win = 1'b1;
    hist = '{rs, rs, rs};
    win_q.delete();
    m_stable = '1;
    m_prev1 = '0; m_prev2 = '0; m_in1 = '0; m_in2 = '0; m_pr1 = '0; m_pr2 = '0;
    m_strobe = 1'b0;
    m_over   = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] l1, l2;
    logic         fe, same;
    snap_t        cur;
    if (!rst) begin
      model_reset();
    end else begin
      l1 = level_of(m_stable[N-1:0]);
      l2 = level_of(m_stable[2*N-1:N]);
      fe = hist[1].frm && !hist[2].frm;
      m_strobe = fe;
      if (fe) begin
        if (!done_gen) m_over = 1'b1;
        if (hist[1].win) begin
          m_in1 = l1; m_in2 = l2;
          m_pr1 = l1 & ~m_prev1;
          m_pr2 = l2 & ~m_prev2;
        end else begin
          m_in1 = '0; m_in2 = '0; m_pr1 = '0; m_pr2 = '0;
        end
        m_prev1 = l1;
        m_prev2 = l2;
      end
      win_q.push_front(hist[1].raw);
      if (win_q.size() > D) void'(win_q.pop_back());
      if (win_q.size() == D) begin
        for (int b = 0; b < 2 * N; b++) begin
          same = 1'b1;
          for (int k = 1; k < D; k++) if (win_q[k][b] != win_q[0][b]) same = 1'b0;
          if (same) m_stable[b] = win_q[0][b];
        end
      end
      cur.raw = {raw_p2, raw_p1};
      cur.frm = frame_clk;
      cur.win = win_reset;
      hist.push_front(cur);
      void'(hist.pop_back());
    end
  endtask

  task automatic check_all();
    check_eq("p1_inputs", 32'(p1_inputs), 32'(m_in1));
    check_eq("p2_inputs", 32'(p2_inputs), 32'(m_in2));
    check_eq("p1_pressed", 32'(p1_pressed), 32'(m_pr1));
    check_eq("p2_pressed", 32'(p2_pressed), 32'(m_pr2));
    check_eq("frame_strobe", 32'(frame_strobe), 32'(m_strobe));
    check_eq("frame_overrun", 32'(frame_overrun), 32'(m_over));
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_frame(input logic done);
    int n;
    n = 0;
    frame_clk = 1'b1;
    done_gen  = done;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (frame_strobe) n++;
    end
    frame_clk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (frame_strobe) n++;
    end
    done_gen = 1'b1;
    check_eq("strobe_width", 32'(n), 32'd1);
  endtask

  initial begin
    int fcnt;
    model_reset();
    ticks(3);
    rst = 1'b1;
    ticks(4);

    // Debounce latency and first press
    raw_p1 = 5'b11110;
    ticks(8);
    check_eq("pre_frame_p1", 32'(p1_inputs), 32'd0);
    run_frame(1'b1);
    check_eq("first_p1_inputs", 32'(p1_inputs), 32'h01);
    check_eq("first_p1_pressed", 32'(p1_pressed), 32'h01);

    // Short glitch rejected
    raw_p2[4] = 1'b0;
    ticks(3);
    raw_p2[4] = 1'b1;
    ticks(2);
    run_frame(1'b1);
    check_eq("glitch_p2_a", 32'(p2_inputs), 32'd0);
    run_frame(1'b1);
    check_eq("glitch_p2_b", 32'(p2_inputs), 32'd0);

    // Held button: level stays, pressed clears
    check_eq("held_p1_inputs", 32'(p1_inputs), 32'h01);
    check_eq("held_p1_pressed", 32'(p1_pressed), 32'd0);

    // SOCD
    raw_p1 = 5'b11000;
    ticks(8);
    run_frame(1'b1);
    check_eq("socd_p1_inputs", 32'(p1_inputs), 32'h04);

    // Lockout then release
    raw_p1    = 5'b10111;
    win_reset = 1'b0;
    ticks(8);
    run_frame(1'b1);
    check_eq("lock_p1_inputs_a", 32'(p1_inputs), 32'd0);
    run_frame(1'b1);
    check_eq("lock_p1_inputs_b", 32'(p1_inputs), 32'd0);
    win_reset = 1'b1;
    ticks(3);
    run_frame(1'b1);
    check_eq("release_p1_inputs", 32'(p1_inputs), 32'h08);
    check_eq("release_p1_pressed", 32'(p1_pressed), 32'd0);

    // Overrun is sticky
    run_frame(1'b0);
    check_eq("overrun_set", 32'(frame_overrun), 32'd1);
    run_frame(1'b1);
    check_eq("overrun_sticky", 32'(frame_overrun), 32'd1);

    // Async reset mid-count, no clock edge
    raw_p1 = 5'b11111;
    ticks(3);
    #2 rst = 1'b0;
    #1;
    check_eq("async_p1_inputs", 32'(p1_inputs), 32'd0);
    check_eq("async_overrun", 32'(frame_overrun), 32'd0);
    check_eq("async_strobe", 32'(frame_strobe), 32'd0);
    model_reset();
    ticks(2);
    rst = 1'b1;

    // Randomized traffic against the model
    fcnt = 5;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if ($urandom_range(0, 7) == 0) raw_p1 = N'($urandom);
      if ($urandom_range(0, 7) == 0) raw_p2 = N'($urandom);
      done_gen = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 29) == 0) win_reset = ~win_reset;
      fcnt--;
      if (fcnt == 0) begin
        frame_clk = ~frame_clk;
        fcnt = $urandom_range(3, 12);
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        rst = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_player_input_capture
`default_nettype wire
